// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, burst size codes,
// requester ids and the size-to-beat-count mapping.
// No logic or timing of its own; imported by the arbiter and its beat counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam logic [1:0] SZ_1W  = 2'b00;
  localparam logic [1:0] SZ_4W  = 2'b01;
  localparam logic [1:0] SZ_8W  = 2'b10;
  localparam logic [1:0] SZ_16W = 2'b11;

  // 5 bits so a full 16-beat count fits.
  localparam int BEAT_W = 5;

  function automatic logic [BEAT_W-1:0] beats_for_size(input logic [1:0] size);
    case (size)
      SZ_1W:   beats_for_size = BEAT_W'(1);
      SZ_4W:   beats_for_size = BEAT_W'(4);
      SZ_8W:   beats_for_size = BEAT_W'(8);
      default: beats_for_size = BEAT_W'(16);
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// Beat counter for one arbiter transaction: loaded at grant, steps per issued beat.
// Latency: last_issue is combinational with the final issue; last_return lags it by 1 cycle.
// Backpressure: the count only advances on cycles where 'issue' is high (stalls hold it).
// Ports: clock/reset; load + load_count start a transaction; issue advances beat;
//        beat is the index of the beat issued this cycle; last_issue / last_return flags.
module mem_arb_beat_ctr
  import mem_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [BEAT_W-1:0] load_count,
  input  logic              issue,
  output logic [BEAT_W-1:0] beat,
  output logic              last_issue,
  output logic              last_return
);

  logic [BEAT_W-1:0] count_q;

  assign last_issue = issue && (beat == (count_q - BEAT_W'(1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat        <= '0;
      count_q     <= '0;
      last_return <= 1'b0;
    end else begin
      // The final read data comes back one cycle after the final issue.
      last_return <= last_issue;
      if (load) begin
        beat    <= '0;
        count_q <= load_count;
      end else if (issue) begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a burst fetch port and a single-word data port onto one word-wide memory port.
// Latency: grant + first issue 1 cycle after a request is seen idle; read data 1 cycle after issue.
// Backpressure: mem_busy stalls issue (beat holds); requesters hold req until their gnt pulse.
// Ports: f_* fetch requester (read bursts of 1/4/8/16 words), d_* data requester
//        (single-word load/store), mem_* memory side. Build option MEM_ARB_RR_EN selects
//        round-robin tie-breaking; otherwise data has fixed priority over fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [1:0]        f_size,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_rw,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_busy
);

  arb_state_t        state, state_nxt;
  req_id_t           winner, owner_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q, gnt_q, rvld_q;
  logic              grant, issue, last_issue, last_return;
  logic [BEAT_W-1:0] beat;

  // Byte-offset bits are architecturally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{f_addr[1:0], d_addr[1:0]};

  assign grant = (state == IDLE) && (f_req || d_req);
  assign issue = (state == ISSUE) && !mem_busy;

`ifdef MEM_ARB_RR_EN
  // Remembers who won last so a tie goes to the other side; starts as data so
  // fetch takes the first tie after reset.
  req_id_t last_win_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      last_win_q <= REQ_D;
    else if (grant) last_win_q <= winner;
  end

  always_comb begin
    winner = REQ_D;
    if (f_req && d_req) winner = (last_win_q == REQ_D) ? REQ_F : REQ_D;
    else if (f_req)     winner = REQ_F;
  end
`else
  always_comb begin
    winner = d_req ? REQ_D : REQ_F;
  end
`endif

  mem_arb_beat_ctr u_beat_ctr (
    .clock       (clock),
    .reset       (reset),
    .load        (grant),
    .load_count  ((winner == REQ_D) ? BEAT_W'(1) : beats_for_size(f_size)),
    .issue       (issue),
    .beat        (beat),
    .last_issue  (last_issue),
    .last_return (last_return)
  );

  // Transaction context captured at grant; requests are ignored afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= REQ_F;
      base_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      gnt_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      gnt_q  <= grant;
      rvld_q <= issue && !rw_q;
      if (grant) begin
        owner_q <= winner;
        if (winner == REQ_D) begin
          base_q  <= {d_addr[ADDR_W-1:2], 2'b00};
          rw_q    <= d_rw;
          wdata_q <= d_wdata;
        end else begin
          base_q  <= {f_addr[ADDR_W-1:2], 2'b00};
          rw_q    <= 1'b0;
          wdata_q <= '0;
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (f_req || d_req) state_nxt = ISSUE;
      ISSUE:   if (last_issue)     state_nxt = DRAIN;
      DRAIN:                       state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // FSM: memory-side outputs, driven only on cycles that actually issue a beat.
  always_comb begin
    mem_enable  = 1'b0;
    mem_addr    = '0;
    mem_rw      = 1'b0;
    mem_data_in = '0;
    if (issue) begin
      mem_enable  = 1'b1;
      mem_addr    = base_q + (ADDR_W'(beat) << 2);  // wraps modulo 2^ADDR_W
      mem_rw      = rw_q;
      mem_data_in = rw_q ? wdata_q : '0;
    end
  end

  assign mem_access_size = SZ_1W;

  // gnt_q is high exactly in the first ISSUE cycle, even if that cycle stalls.
  assign f_gnt    = gnt_q       && (owner_q == REQ_F);
  assign d_gnt    = gnt_q       && (owner_q == REQ_D);
  assign f_rvalid = rvld_q      && (owner_q == REQ_F);
  assign d_rvalid = rvld_q      && (owner_q == REQ_D);
  assign f_done   = last_return && (owner_q == REQ_F);
  assign d_done   = last_return && (owner_q == REQ_D);
  assign f_rdata  = f_rvalid ? mem_data_out : '0;
  assign d_rdata  = d_rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, directed scenarios and random traffic
// checked against an address/timing/data model derived from the transaction rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_rw, mem_busy;
  logic [31:0] f_addr, d_addr, d_wdata, mem_data_out;
  logic [1:0]  f_size;
  logic        f_gnt, f_rvalid, f_done, d_gnt, d_rvalid, d_done, mem_rw, mem_enable;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_data_in;
  logic [1:0]  mem_access_size;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_size(f_size), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_done(f_done),
    .d_req(d_req), .d_addr(d_addr), .d_rw(d_rw), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_data_out(mem_data_out),
    .mem_busy(mem_busy)
  );

  logic [137:0] all_outs;
  assign all_outs = {f_gnt, f_rvalid, f_rdata, f_done, d_gnt, d_rvalid, d_rdata, d_done,
                     mem_addr, mem_data_in, mem_access_size, mem_rw, mem_enable};

  int errors = 0;
  int checks = 0;

  // ---------------- memory model (registered read, 1-cycle latency) ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  logic [31:0] mem_arr [0:1023];
  bit          mem_wr  [0:1023];

  always @(posedge clock) begin
    if (mem_enable) begin
      if (mem_rw) begin
        mem_arr[mem_addr[11:2]] <= mem_data_in;
        mem_wr[mem_addr[11:2]]  <= 1'b1;
      end else begin
        mem_data_out <= mem_wr[mem_addr[11:2]] ? mem_arr[mem_addr[11:2]] : init_word(mem_addr);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_arr [0:1023];
  bit          ref_wr  [0:1023];
  logic [31:0] exp_addr[$], exp_rd[$];
  int          exp_rv[$];
  int          exp_done;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_wr[a[11:2]] ? ref_arr[a[11:2]] : init_word(a);
  endfunction

  // Cycle 0 = request seen in IDLE. Beats issue from cycle 1 on every non-busy cycle,
  // data returns one cycle later, done comes with the final return.
  function automatic void build_model(input logic [31:0] addr, input logic [1:0] size,
                                      input bit is_f, input bit rw, input logic [31:0] wdata,
                                      input logic [31:0] busy_mask);
    int          beats_tab [4];
    int          n, issued;
    logic [31:0] a;
    beats_tab[0] = 1; beats_tab[1] = 4; beats_tab[2] = 8; beats_tab[3] = 16;
    n = is_f ? beats_tab[size] : 1;
    issued = 0;
    exp_done = -1;
    exp_addr.delete(); exp_rd.delete(); exp_rv.delete();
    for (int c = 1; issued < n && c < 64; c++) begin
      if (!(c < 32 && busy_mask[c])) begin
        a = {addr[31:2], 2'b00} + 32'(4 * issued);
        exp_addr.push_back(a);
        if (!rw) begin
          exp_rd.push_back(ref_word(a));
          exp_rv.push_back(c + 1);
        end
        issued++;
        exp_done = c + 1;
      end
    end
    if (rw) begin
      ref_arr[addr[11:2]] = wdata;
      ref_wr[addr[11:2]]  = 1'b1;
    end
  endfunction

  // ---------------- transaction driver / monitor ----------------
  logic [31:0] obs_addr[$], obs_wd[$], obs_rd[$];
  bit          obs_rw[$];
  int          obs_rv[$];
  int          gnt_cyc, gnt_cnt, done_cyc;
  bit          other_act;

  task automatic drive_txn(input bit is_f, input logic [31:0] addr, input logic [1:0] size,
                           input bit rw, input logic [31:0] wdata, input logic [31:0] busy_mask);
    bit got_gnt;
    got_gnt = 1'b0;
    gnt_cyc = -1; gnt_cnt = 0; done_cyc = -1; other_act = 1'b0;
    obs_addr.delete(); obs_wd.delete(); obs_rd.delete(); obs_rw.delete(); obs_rv.delete();
    for (int c = 0; c < 48; c++) begin
      @(posedge clock); #1;
      mem_busy = (c < 32) ? busy_mask[c] : 1'b0;
      if (c == 0) begin
        f_req = is_f;  f_addr = addr; f_size = size;
        d_req = !is_f; d_addr = addr; d_rw = rw; d_wdata = wdata;
      end else if (got_gnt) begin
        f_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clock);
      if (is_f ? f_gnt : d_gnt) begin
        gnt_cnt++;
        if (gnt_cyc < 0) gnt_cyc = c;
        got_gnt = 1'b1;
      end
      if (is_f ? (d_gnt | d_rvalid | d_done) : (f_gnt | f_rvalid | f_done)) other_act = 1'b1;
      if (mem_enable) begin
        obs_addr.push_back(mem_addr); obs_rw.push_back(mem_rw); obs_wd.push_back(mem_data_in);
      end
      if (is_f ? f_rvalid : d_rvalid) begin
        obs_rd.push_back(is_f ? f_rdata : d_rdata);
        obs_rv.push_back(c);
      end
      if (is_f ? f_done : d_done) begin
        done_cyc = c;
        break;
      end
    end
    @(posedge clock); #1;
    f_req = 1'b0; d_req = 1'b0; mem_busy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    f_req = 1'b1; d_req = 1'b1; f_addr = 32'h100; d_addr = 32'h200;
    repeat (2) @(negedge clock);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    @(posedge clock); #1;
    f_req = 1'b0; d_req = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL idle_outputs: got %h want 0", all_outs);
    end
  endtask

  task automatic test_single_fetch();
    build_model(32'h80020003, 2'b00, 1'b1, 1'b0, '0, '0);
    drive_txn(1'b1, 32'h80020003, 2'b00, 1'b0, '0, '0);
    checks++;
    if (gnt_cyc !== 1 || gnt_cnt !== 1) begin
      errors++; $display("FAIL single_gnt: got cycle %0d count %0d want cycle 1 count 1", gnt_cyc, gnt_cnt);
    end
    checks++;
    if (obs_addr.size() !== 1) begin
      errors++; $display("FAIL single_issue_count: got %0d want 1", obs_addr.size());
    end else if (obs_addr[0] !== 32'h80020000) begin
      errors++; $display("FAIL single_addr: got %h want 80020000", obs_addr[0]);
    end
    checks++;
    if (obs_rd.size() !== 1 || obs_rv.size() !== 1) begin
      errors++; $display("FAIL single_rvalid_count: got %0d want 1", obs_rd.size());
    end else if (obs_rv[0] !== 2 || obs_rd[0] !== init_word(32'h80020000)) begin
      errors++; $display("FAIL single_rdata: got %h at cycle %0d want %h at cycle 2",
                         obs_rd[0], obs_rv[0], init_word(32'h80020000));
    end
    checks++;
    if (done_cyc !== 2) begin
      errors++; $display("FAIL single_done: got cycle %0d want 2", done_cyc);
    end
  endtask

  task automatic test_burst16();
    build_model(32'h80020000, 2'b11, 1'b1, 1'b0, '0, 32'h0000_0300);
    drive_txn(1'b1, 32'h80020000, 2'b11, 1'b0, '0, 32'h0000_0300);
    checks++;
    if (obs_addr.size() !== 16 || obs_rd.size() !== 16) begin
      errors++; $display("FAIL burst_beats: got %0d issues %0d rvalids want 16", obs_addr.size(), obs_rd.size());
    end
    for (int i = 0; i < 16; i++) begin
      if (i < obs_addr.size()) begin
        checks++;
        if (obs_addr[i] !== 32'h80020000 + 32'(4 * i)) begin
          errors++; $display("FAIL burst_addr[%0d]: got %h want %h", i, obs_addr[i], 32'h80020000 + 32'(4 * i));
        end
      end
      if (i < obs_rd.size()) begin
        checks++;
        if (obs_rd[i] !== exp_rd[i] || obs_rv[i] !== exp_rv[i]) begin
          errors++; $display("FAIL burst_rdata[%0d]: got %h at %0d want %h at %0d",
                             i, obs_rd[i], obs_rv[i], exp_rd[i], exp_rv[i]);
        end
      end
    end
    checks++;
    if (done_cyc !== 19) begin
      errors++; $display("FAIL burst_done: got cycle %0d want 19", done_cyc);
    end
  endtask

  task automatic test_write_read();
    build_model(32'h80020010, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF, '0);
    drive_txn(1'b0, 32'h80020010, 2'b00, 1'b1, 32'hDEADBEEF, '0);
    checks++;
    if (obs_addr.size() !== 1) begin
      errors++; $display("FAIL write_issue_count: got %0d want 1", obs_addr.size());
    end else if (obs_addr[0] !== 32'h80020010 || obs_rw[0] !== 1'b1 || obs_wd[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_beat: got addr %h rw %b data %h want 80020010 1 deadbeef",
                         obs_addr[0], obs_rw[0], obs_wd[0]);
    end
    checks++;
    if (gnt_cyc !== 1 || done_cyc !== 2 || obs_rd.size() !== 0) begin
      errors++; $display("FAIL write_timing: got gnt %0d done %0d rvalids %0d want 1 2 0",
                         gnt_cyc, done_cyc, obs_rd.size());
    end
    build_model(32'h80020010, 2'b00, 1'b0, 1'b0, '0, '0);
    drive_txn(1'b0, 32'h80020010, 2'b00, 1'b0, '0, '0);
    checks++;
    if (obs_rd.size() !== 1) begin
      errors++; $display("FAIL readback_count: got %0d want 1", obs_rd.size());
    end else if (obs_rd[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL readback_data: got %h want deadbeef", obs_rd[0]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wrap_exp [4];
    wrap_exp[0] = 32'hFFFFFFF8; wrap_exp[1] = 32'hFFFFFFFC;
    wrap_exp[2] = 32'h00000000; wrap_exp[3] = 32'h00000004;
    build_model(32'hFFFFFFF8, 2'b01, 1'b1, 1'b0, '0, '0);
    drive_txn(1'b1, 32'hFFFFFFF8, 2'b01, 1'b0, '0, '0);
    checks++;
    if (obs_addr.size() !== 4 || done_cyc !== 5) begin
      errors++; $display("FAIL wrap_beats: got %0d issues done %0d want 4 done 5", obs_addr.size(), done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_addr.size()) begin
        checks++;
        if (obs_addr[i] !== wrap_exp[i]) begin
          errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, obs_addr[i], wrap_exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midburst();
    int pre_rv;
    bit late;
    pre_rv = 0; late = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      mem_busy = 1'b0;
      if (c == 0) begin f_req = 1'b1; f_addr = 32'h80020100; f_size = 2'b10; end
      if (c == 2) f_req = 1'b0;
      if (c == 5) reset = 1'b1;
      if (c == 8) reset = 1'b0;
      @(negedge clock);
      if (c < 5 && f_rvalid) pre_rv++;
      if (c >= 5 && (f_gnt | f_rvalid | f_done | d_gnt | d_rvalid | d_done | mem_enable)) late = 1'b1;
      if (c == 5) begin
        checks++;
        if (all_outs !== '0) begin
          errors++; $display("FAIL midreset_outputs: got %h want 0", all_outs);
        end
      end
    end
    checks++;
    if (pre_rv !== 3) begin
      errors++; $display("FAIL midreset_pre_rvalids: got %0d want 3", pre_rv);
    end
    checks++;
    if (late !== 1'b0) begin
      errors++; $display("FAIL midreset_activity: got %b want 0", late);
    end
    build_model(32'h80020104, 2'b00, 1'b1, 1'b0, '0, '0);
    drive_txn(1'b1, 32'h80020104, 2'b00, 1'b0, '0, '0);
    checks++;
    if (gnt_cyc !== 1 || done_cyc !== 2 || obs_rd.size() !== 1) begin
      errors++; $display("FAIL after_reset_txn: got gnt %0d done %0d rvalids %0d want 1 2 1",
                         gnt_cyc, done_cyc, obs_rd.size());
    end else if (obs_rd[0] !== exp_rd[0]) begin
      errors++; $display("FAIL after_reset_data: got %h want %h", obs_rd[0], exp_rd[0]);
    end
  endtask

  task automatic test_tie();
    bit gwho[$];   // 1 = fetch won, 0 = data won
    int gcyc[$];
    bit exp_f, last_f;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    for (int c = 0; c < 20 && gwho.size() < 4; c++) begin
      @(posedge clock); #1;
      mem_busy = 1'b0;
      f_req = 1'b1; f_addr = 32'h80020040; f_size = 2'b00;
      d_req = 1'b1; d_addr = 32'h80020080; d_rw = 1'b0;
      @(negedge clock);
      if (f_gnt) begin gwho.push_back(1'b1); gcyc.push_back(c); end
      if (d_gnt) begin gwho.push_back(1'b0); gcyc.push_back(c); end
    end
    @(posedge clock); #1;
    f_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clock);
    checks++;
    if (gwho.size() !== 4) begin
      errors++; $display("FAIL tie_grant_count: got %0d want 4", gwho.size());
    end
    last_f = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_f = !last_f;
`else
      exp_f = 1'b0;
`endif
      last_f = exp_f;
      if (i < gwho.size()) begin
        checks++;
        if (gwho[i] !== exp_f || gcyc[i] !== 1 + 3 * i) begin
          errors++; $display("FAIL tie_grant[%0d]: got fetch=%b at %0d want fetch=%b at %0d",
                             i, gwho[i], gcyc[i], exp_f, 1 + 3 * i);
        end
      end
    end
  endtask

  task automatic test_random();
    bit          is_f, rw;
    logic [31:0] addr, wdata, busy;
    logic [1:0]  size;
    for (int t = 0; t < 14; t++) begin
      is_f  = 1'($urandom_range(0, 1));
      rw    = !is_f && ($urandom_range(0, 1) == 1);
      addr  = $urandom;
      wdata = $urandom;
      size  = 2'($urandom_range(0, 3));
      busy  = $urandom & $urandom & $urandom & 32'hFFFF_FFFC;
      build_model(addr, size, is_f, rw, wdata, busy);
      drive_txn(is_f, addr, size, rw, wdata, busy);
      checks++;
      if (gnt_cyc !== 1 || gnt_cnt !== 1 || done_cyc !== exp_done || other_act) begin
        errors++; $display("FAIL rand%0d_ctrl: got gnt %0d x%0d done %0d other %b want gnt 1 x1 done %0d other 0",
                           t, gnt_cyc, gnt_cnt, done_cyc, other_act, exp_done);
      end
      checks++;
      if (obs_addr.size() !== exp_addr.size() || obs_rd.size() !== exp_rd.size()) begin
        errors++; $display("FAIL rand%0d_counts: got %0d issues %0d rvalids want %0d %0d",
                           t, obs_addr.size(), obs_rd.size(), exp_addr.size(), exp_rd.size());
      end
      foreach (exp_addr[i]) begin
        if (i < obs_addr.size()) begin
          checks++;
          if (obs_addr[i] !== exp_addr[i] || obs_rw[i] !== rw || (rw && obs_wd[i] !== wdata)) begin
            errors++; $display("FAIL rand%0d_issue[%0d]: got %h rw %b wd %h want %h rw %b wd %h",
                               t, i, obs_addr[i], obs_rw[i], obs_wd[i], exp_addr[i], rw, wdata);
          end
        end
      end
      foreach (exp_rd[i]) begin
        if (i < obs_rd.size()) begin
          checks++;
          if (obs_rd[i] !== exp_rd[i] || obs_rv[i] !== exp_rv[i]) begin
            errors++; $display("FAIL rand%0d_rdata[%0d]: got %h at %0d want %h at %0d",
                               t, i, obs_rd[i], obs_rv[i], exp_rd[i], exp_rv[i]);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_busy = 1'b0;
    f_req = 1'b0; f_addr = '0; f_size = '0;
    d_req = 1'b0; d_addr = '0; d_rw = 1'b0; d_wdata = '0;
    test_reset();
    test_single_fetch();
    test_burst16();
    test_write_read();
    test_wrap();
    test_reset_midburst();
    test_tie();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and burst sequencer in front of the byte-addressed `memory` block. It shares the memory between an instruction-fetch requester (read-only, bursts of 1/4/8/16 words) and a data requester (single-word load/store). It issues one word-sized memory access per cycle, stalls on `busy`, and returns read data with per-beat valid strobes. It sits between the pipeline front/back ends and `memory`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `f_req`  in  1  fetch request; held until `f_gnt`
- `f_addr`  in  ADDR_W  fetch base byte address; bits [1:0] ignored
- `f_size`  in  2  burst length: 00=1, 01=4, 10=8, 11=16 words
- `f_gnt`  out  1  one-cycle pulse: fetch accepted, first beat issued this cycle
- `f_rvalid`  out  1  fetch read beat valid
- `f_rdata`  out  DATA_W  fetch read data
- `f_done`  out  1  one-cycle pulse with the final fetch beat
- `d_req`  in  1  data request; held until `d_gnt`
- `d_addr`  in  ADDR_W  data byte address; bits [1:0] ignored
- `d_rw`  in  1  1=write, 0=read
- `d_wdata`  in  DATA_W  write data
- `d_gnt`, `d_rvalid`, `d_rdata`, `d_done`: out, same meaning as the fetch signals
- `mem_addr`  out  ADDR_W  memory address
- `mem_data_in`  out  DATA_W  memory write data
- `mem_access_size`  out  2  always 00: every beat is a single-word access
- `mem_rw`  out  1  memory write strobe qualifier
- `mem_enable`  out  1  memory access enable
- `mem_data_out`  in  DATA_W  memory read data, registered 1 cycle after the issue
- `mem_busy`  in  1  memory stall; no issue while high

## Operation
- **States:** IDLE, ISSUE, DRAIN.
- **IDLE:** if any request is pending, pick a winner. Latch its address (low 2 bits zeroed), its beat count (fetch: per `f_size`; data: 1) and `rw`. Go to ISSUE.
- **ISSUE:** the first cycle asserts the winner's `gnt`.
  - Each cycle with `mem_busy`=0: `mem_enable`=1, `mem_addr` = base + 4*beat (mod 2^ADDR_W), then beat++.
  - When `mem_busy`=1: `mem_enable`=0 and the beat counter holds. `gnt` still pulses only once.
  - After the last beat is issued, go to DRAIN.
- **DRAIN:** one cycle. It carries the final `rvalid` for reads. `done` pulses (reads and writes). Then go to IDLE.
- **Read beats:** a beat issued in cycle k gives `rvalid`=1 and `rdata`=`mem_data_out` in cycle k+1. Beats are returned in address order.
- **Writes:** `mem_rw`=1 and `mem_data_in`=`d_wdata` latched at grant. There is exactly one beat, and `rvalid` stays low.
- **Request changes:** after `gnt`, requests are ignored. Dropping `req` does not abort the transaction.
- **Arbitration:** a single requester wins immediately. For simultaneous requests, see Configuration.
- **Reset (any time):** state=IDLE and the beat counter clears. An in-flight beat is discarded: no `rvalid`, no `done`.
- **Reset values:** every output is 0, and `mem_access_size`=00.

## Timing
- Request seen in IDLE at cycle T: `gnt` and the first issue occur at T+1.
- For an N-beat read with no stalls: `rvalid` at T+2..T+N+1, `done` at T+N+1, IDLE at T+N+2, next grant no earlier than T+N+3.
- Each stalled cycle adds one cycle of latency and adds no `rvalid` gaps other than the stalled slots.
- Write: `gnt` and issue at T+1, `done` at T+2.
- Minimum occupancy is 3 cycles per transaction, including IDLE.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin. A last-winner register (reset value = data) gives the tie to the requester not granted last, so fetch wins the first tie after reset.
- **Undefined:** fixed priority, with data always beating fetch. The last-winner register is not instantiated.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum {IDLE, ISSUE, DRAIN}
  - access-size encodings SZ_1W=00, SZ_4W=01, SZ_8W=10, SZ_16W=11
  - `beats_for_size()` mapping to 1/4/8/16
  - requester id enum {REQ_F, REQ_D}
- **Sub-module `mem_arb_beat_ctr`:** a 5-bit beat counter with load(count), stall-aware increment, `last_issue` flag and a registered `last_return` flag.

## Test plan
- **Single fetch:** `f_req`, `f_addr`=0x80020003, `f_size`=00 -> `f_gnt` at T+1 with `mem_addr`=0x80020000, `f_rvalid` and `f_done` at T+2 with the memory word.
- **16-beat burst:** 16-word burst from 0x80020000, `mem_busy` high for 2 cycles mid-burst -> 16 `f_rvalid`s at addresses +0..+0x3C in order, `f_done` on the 16th at T+19.
- **Simultaneous requests:** `f_req` and `d_req` at cycle T -> with the macro, fetch is granted first and data follows. Without it, data is granted first. Repeat the tie: with the macro, the winner alternates.
- **Write then read:** write 0xDEADBEEF to 0x80020010 (`mem_rw`=1 at T+1, `d_done` at T+2), then read the same address -> `d_rdata`=0xDEADBEEF.
- **Reset mid-burst:** `reset` during beat 5 of an 8-beat fetch -> all outputs 0 immediately, no further `f_rvalid` or `f_done`, and a fresh request after release is served normally.
- **Wrap-around:** 4-beat fetch at 0xFFFFFFF8 -> `mem_addr` sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
